// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access path: funct3 sizes, FSM states,
// request legality check and sub-word store merge.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RMW_RD = 2'd2,
    S_RMW_WR = 2'd3
  } state_e;

  // Misaligned halfword/word, reserved size, or unsigned size on a store.
  function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [15:0] wd,
                                             input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] m;
    m = old;
    if (f3 == F3_H) begin
      if (off[1]) m[31:16] = wd;
      else        m[15:0]  = wd;
    end else begin
      case (off)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed byte/halfword lane out of a RAM word and sign- or
// zero-extends it according to the load size. Purely combinational.
module load_align_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer for a word-wide single-port RAM (1-cycle read).
// SW 1 cycle, loads 2, SB/SH 3 (read-modify-write); stall held until the final cycle.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              fault,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [MEM_AW-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [31:0]       merged_q, merged_d;
  logic [31:0]       load_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

  load_align_ext u_align (
    .word_i   (mem_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    off_d      = off_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    merged_d   = merged_q;
    stall      = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    fault      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = waddr_q;
    mem_wdata  = 32'd0;

    case (state_q)
      S_IDLE: begin
        mem_addr = req_addr[MEM_AW+1:2];
        if (req_valid) begin
          if (is_fault(req_we, req_funct3, req_addr[1:0])) begin
            fault = 1'b1;
          end else begin
            f3_d    = req_funct3;
            off_d   = req_addr[1:0];
            waddr_d = req_addr[MEM_AW+1:2];
            wdata_d = req_wdata[15:0];
            if (!req_we) begin
              mem_re  = 1'b1;
              stall   = 1'b1;
              state_d = S_LOAD;
            end else if (req_funct3 == F3_W) begin
              mem_we     = 1'b1;
              mem_wdata  = req_wdata;
              resp_valid = 1'b1;
            end else begin
              mem_re  = 1'b1;
              stall   = 1'b1;
              state_d = S_RMW_RD;
            end
          end
        end
      end
      S_LOAD: begin
        resp_valid = 1'b1;
        resp_rdata = load_data;
        state_d    = S_IDLE;
      end
      S_RMW_RD: begin
        stall    = 1'b1;
        merged_d = merge_lane(mem_rdata, wdata_q, f3_q, off_q);
        state_d  = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_we     = 1'b1;
        mem_wdata  = merged_q;
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset aborts any access in flight: nothing reaches the RAM or the pipeline.
    if (reset) begin
      stall      = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'd0;
      fault      = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      waddr_q  <= '0;
      wdata_q  <= 16'd0;
      merged_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table against a behavioural RAM, plus
// reset-abort and mid-access req_valid drop sequences.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, fault, mem_re, mem_we;
  logic [31:0] resp_rdata, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [9:0]  mem_addr;

  logic [31:0] ram [0:1023];

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_fault;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mwdata;
    logic [9:0]  exp_maddr;
  } vec_t;

  vec_t vecs [0:20];
  vec_t sb_q [$];

  dmem_access_ctrl #(.MEM_AW(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .fault      (fault),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".stall"}, 32'(stall), 32'd0);
    chk({name, ".resp_valid"}, 32'(resp_valid), 32'd0);
    chk({name, ".resp_rdata"}, resp_rdata, 32'd0);
    chk({name, ".fault"}, 32'(fault), 32'd0);
    chk({name, ".mem_re"}, 32'(mem_re), 32'd0);
    chk({name, ".mem_we"}, 32'(mem_we), 32'd0);
    chk({name, ".mem_addr"}, 32'(mem_addr), 32'd0);
    chk({name, ".mem_wdata"}, mem_wdata, 32'd0);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic flt, input int lat,
                              input logic [31:0] rdata, input logic [31:0] mwdata,
                              input logic [9:0] maddr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_fault = flt;
    v.exp_lat = lat; v.exp_rdata = rdata; v.exp_mwdata = mwdata; v.exp_maddr = maddr;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int cycles, stall_cnt, re_cnt, we_cnt;
    logic done;
    logic [31:0] w_dat;
    logic [9:0]  w_adr;
    vec_t e;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    sb_q.push_back(v);
    cycles = 0; stall_cnt = 0; re_cnt = 0; we_cnt = 0; done = 1'b0;
    w_dat = 32'd0; w_adr = 10'd0;
    while (!done && cycles < 10) begin
      @(negedge clk);
      cycles++;
      if (stall) stall_cnt++;
      if (mem_re) re_cnt++;
      if (mem_we) begin we_cnt++; w_dat = mem_wdata; w_adr = mem_addr; end
      if (resp_valid || fault) begin
        done = 1'b1;
        e = sb_q.pop_front();
        chk({tag, ".fault"}, 32'(fault), 32'(e.exp_fault));
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(!e.exp_fault));
        chk({tag, ".latency"}, 32'(cycles), 32'(e.exp_lat));
        chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(e.exp_lat - 1));
        chk({tag, ".re_pulses"}, 32'(re_cnt), (!e.exp_fault && e.exp_lat > 1) ? 32'd1 : 32'd0);
        chk({tag, ".we_pulses"}, 32'(we_cnt), (!e.exp_fault && e.we) ? 32'd1 : 32'd0);
        chk({tag, ".resp_rdata"}, resp_rdata, (!e.exp_fault && !e.we) ? e.exp_rdata : 32'd0);
        if (!e.exp_fault && e.we) begin
          chk({tag, ".mem_wdata"}, w_dat, e.exp_mwdata);
          chk({tag, ".mem_addr"}, 32'(w_adr), 32'(e.exp_maddr));
        end
      end
    end
    if (!done) begin
      checks++;
      $display("FAIL %s.timeout: no resp_valid/fault within %0d cycles", tag, cycles);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
    ram[10'h40] = 32'h80FF_1234;

    vecs[0]  = mk(0, 3'b000, 32'h103, 0, 0, 2, 32'hFFFF_FF80, 0, 0);
    vecs[1]  = mk(0, 3'b101, 32'h102, 0, 0, 2, 32'h0000_80FF, 0, 0);
    vecs[2]  = mk(0, 3'b001, 32'h102, 0, 0, 2, 32'hFFFF_80FF, 0, 0);
    vecs[3]  = mk(0, 3'b100, 32'h100, 0, 0, 2, 32'h0000_0034, 0, 0);
    vecs[4]  = mk(0, 3'b010, 32'h100, 0, 0, 2, 32'h80FF_1234, 0, 0);
    vecs[5]  = mk(1, 3'b010, 32'h100, 32'h1122_3344, 0, 1, 0, 32'h1122_3344, 10'h40);
    vecs[6]  = mk(1, 3'b000, 32'h101, 32'hFFFF_FFAB, 0, 3, 0, 32'h1122_AB44, 10'h40);
    vecs[7]  = mk(0, 3'b010, 32'h100, 0, 0, 2, 32'h1122_AB44, 0, 0);
    vecs[8]  = mk(1, 3'b001, 32'h102, 32'h1234_BEEF, 0, 3, 0, 32'hBEEF_AB44, 10'h40);
    vecs[9]  = mk(0, 3'b001, 32'h102, 0, 0, 2, 32'hFFFF_BEEF, 0, 0);
    vecs[10] = mk(1, 3'b010, 32'h8, 32'hDEAD_BEEF, 0, 1, 0, 32'hDEAD_BEEF, 10'h2);
    vecs[11] = mk(0, 3'b000, 32'h9, 0, 0, 2, 32'hFFFF_FFBE, 0, 0);
    vecs[12] = mk(0, 3'b010, 32'hFFFF_F008, 0, 0, 2, 32'hDEAD_BEEF, 0, 0);
    vecs[13] = mk(0, 3'b010, 32'h6, 0, 1, 1, 0, 0, 0);
    vecs[14] = mk(1, 3'b001, 32'h3, 32'h5555, 1, 1, 0, 0, 0);
    vecs[15] = mk(0, 3'b011, 32'h0, 0, 1, 1, 0, 0, 0);
    vecs[16] = mk(1, 3'b100, 32'h100, 32'h77, 1, 1, 0, 0, 0);
    vecs[17] = mk(0, 3'b110, 32'h0, 0, 1, 1, 0, 0, 0);
    vecs[18] = mk(1, 3'b111, 32'h8, 32'h1, 1, 1, 0, 0, 0);
    vecs[19] = mk(0, 3'b101, 32'h101, 0, 1, 1, 0, 0, 0);
    vecs[20] = mk(1, 3'b000, 32'h103, 32'h0000_0077, 0, 3, 0, 32'h77EF_AB44, 10'h40);

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    @(negedge clk);
    chk_all_zero("reset_idle");
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_we = 1'b1; req_wdata = 32'h1;
    #1;
    chk_all_zero("reset_req");
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    for (int i = 0; i <= 20; i++) run_vec(i, vecs[i]);

    // Reset landing on the write cycle of a halfword RMW must not touch the RAM.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h100; req_wdata = 32'h5555;
    @(negedge clk);
    chk("rst_rmw.stall_c1", 32'(stall), 32'd1);
    @(negedge clk);
    chk("rst_rmw.stall_c2", 32'(stall), 32'd1);
    chk("rst_rmw.we_c2", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rmw.we_in_reset", 32'(mem_we), 32'd0);
    chk("rst_rmw.resp_in_reset", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    @(negedge clk);
    chk_all_zero("after_reset");
    run_vec(21, mk(0, 3'b010, 32'h100, 0, 0, 2, 32'h77EF_AB44, 0, 0));

    // Request withdrawn after acceptance: the load still completes from captured state.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h8;
    @(posedge clk); #1;
    req_valid = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(negedge clk);
    chk("drop.resp_valid", 32'(resp_valid), 32'd1);
    chk("drop.resp_rdata", resp_rdata, 32'h0000_00EF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
